// File: rtl/ram_pkg.sv
// Shared definitions for the simple dual-port RAM with power-on clear:
// read-during-write policy selectors and the controller state type.
package ram_pkg;

  // Same-address read-during-write behaviour selectors
  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

  // Controller states: clearing the array, then serving requests
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read output stage: carries data, valid and error flags through
// LATENCY register stages. The last stage only loads on a valid beat so
// rd_data holds its previous value between reads.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err
);

  logic [LATENCY-1:0]    vld_q;
  logic [LATENCY-1:0]    err_q;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  // First stage captures the word looked up on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q[0]  <= 1'b0;
      err_q[0]  <= 1'b0;
      data_q[0] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        err_q[0]  <= in_err;
        data_q[0] <= in_data;
      end
    end
  end

  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    // Later stages move a beat forward only when the stage before holds one
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[g]  <= 1'b0;
        err_q[g]  <= 1'b0;
        data_q[g] <= '0;
      end else begin
        vld_q[g] <= vld_q[g-1];
        if (vld_q[g-1]) begin
          err_q[g]  <= err_q[g-1];
          data_q[g] <= data_q[g-1];
        end
      end
    end
  end

  assign rd_valid = vld_q[LATENCY-1];
  assign rd_err   = vld_q[LATENCY-1] & err_q[LATENCY-1];
  assign rd_data  = data_q[LATENCY-1];

endmodule

// File: rtl/ram_sdp_init.sv
// Simple dual-port RAM (one write port, one read port, one clock) with
// byte enables, out-of-range error reporting and an automatic clear of
// the whole array after every reset. Requests are ignored while clearing.
module ram_sdp_init
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = RDW_WRITE_FIRST
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err,
  output logic                    wr_err,
  output logic                    init_busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH <= 0 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("ram_sdp_init: DATA_WIDTH must be a positive multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $error("ram_sdp_init: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("ram_sdp_init: RD_LATENCY must be 1 or 2");
  end
  if (RDW_MODE != RDW_WRITE_FIRST && RDW_MODE != RDW_READ_FIRST) begin : g_bad_rdw
    $error("ram_sdp_init: RDW_MODE must be RDW_WRITE_FIRST or RDW_READ_FIRST");
  end

  ram_state_t            state, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  ready;
  logic                  init_we;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
  assign wr_ok       = ready & wr_en & wr_in_range & ~rst;
  assign rd_ok       = ready & rd_en & ~rst;

  // State register: every reset restarts the clear from scratch
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_next;
  end

  // Leave INIT once the last address has been cleared
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == LAST_ADDR) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // Decode state into busy flag, request gating and clear strobe
  always_comb begin
    init_busy = 1'b0;
    ready     = 1'b0;
    init_we   = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        init_we   = ~rst;
      end
      READY:   ready = 1'b1;
      default: init_busy = 1'b1;
    endcase
  end

  // Clear address counter walks 0..DEPTH-1 while in INIT
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if (state == INIT) begin
      if (init_cnt == LAST_ADDR) init_cnt <= '0;
      else                       init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  // Storage array: clear writes while initialising, byte-masked writes after
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Out-of-range writes are dropped and flagged for one cycle
  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= ready & wr_en & ~wr_in_range;
  end

  // Read lookup, with write-first forwarding of enabled bytes on a collision
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == RDW_WRITE_FIRST && wr_ok && wr_addr == rd_addr) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .LATENCY    (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_ok),
    .in_err   (~rd_in_range),
    .in_data  (rd_word),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

endmodule

// File: tb/tb_ram_sdp_init.sv
// Directed bench for ram_sdp_init. Two instances share all inputs:
// dut_a uses defaults (DEPTH 256, latency 1, write-first) and dut_b uses
// DEPTH 200, latency 2, read-first, so one stimulus stream covers both.
module tb_ram_sdp_init;
  import ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [7:0]  rd_addr;

  logic [31:0] a_rd_data, b_rd_data;
  logic        a_rd_valid, b_rd_valid;
  logic        a_rd_err, b_rd_err;
  logic        a_wr_err, b_wr_err;
  logic        a_init_busy, b_init_busy;

  int errors = 0;
  int checks = 0;
  int a_done, b_done, spurious;

  ram_sdp_init dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_valid(a_rd_valid), .rd_err(a_rd_err), .wr_err(a_wr_err),
    .init_busy(a_init_busy)
  );

  ram_sdp_init #(
    .DEPTH(200), .RD_LATENCY(2), .RDW_MODE(RDW_READ_FIRST)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(b_rd_data),
    .rd_valid(b_rd_valid), .rd_err(b_rd_err), .wr_err(b_wr_err),
    .init_busy(b_init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                               input logic [3:0] be, input logic re, input logic [7:0] ra);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ra;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, 1'b0, 8'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] pack(input logic v, input logic e, input logic [31:0] d);
    return {v, e, d};
  endfunction

  function automatic logic [31:0] expBurst(input int a);
    return (a == 5) ? 32'hDE22BE44 : 32'h0BAD0000 + 32'(a);
  endfunction

  // Counts edges after rst release until each init_busy falls; optionally
  // pokes writes/reads during the clear, which must be ignored.
  task automatic waitInit(input bit poke, output int ad, output int bd, output int sp);
    ad = 0;
    bd = 0;
    sp = 0;
    for (int i = 1; i <= 400; i++) begin
      if (poke && i < 20)
        applyStimulus(1'b1, (i == 10) ? 8'd210 : 8'd6, 32'hFFFFFFFF, 4'hF, 1'b1, 8'd6);
      else
        idle();
      tick();
      if (ad == 0 && !a_init_busy) ad = i;
      if (bd == 0 && !b_init_busy) bd = i;
      if (a_rd_valid || b_rd_valid || a_wr_err || b_wr_err) sp++;
      if (ad != 0 && bd != 0) break;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst_busy_a", {33'd0, a_init_busy}, 34'd1);
    checkOutput("rst_busy_b", {33'd0, b_init_busy}, 34'd1);
    checkOutput("rst_rd_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b0, 1'b0, 32'h0));
    checkOutput("rst_rd_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b0, 1'b0, 32'h0));
    checkOutput("rst_wr_err", {32'd0, a_wr_err, b_wr_err}, 34'd0);

    $display("[TB] clear sequence with ignored requests");
    rst = 1'b0;
    waitInit(1'b1, a_done, b_done, spurious);
    checkOutput("init_cycles_a", 34'(a_done), 34'd256);
    checkOutput("init_cycles_b", 34'(b_done), 34'd200);
    checkOutput("init_ignored", 34'(spurious), 34'd0);

    $display("[TB] sweep read of every address");
    for (int i = 0; i <= 257; i++) begin
      applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, i < 256, 8'(i));
      tick();
      if (i < 256) checkOutput("sweep_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'h0));
      else         checkOutput("sweep_a_end", {33'd0, a_rd_valid}, 34'd0);
      if (i == 0)       checkOutput("sweep_b_lat", {33'd0, b_rd_valid}, 34'd0);
      else if (i < 257) checkOutput("sweep_b", pack(b_rd_valid, b_rd_err, b_rd_data),
                                    pack(1'b1, (i - 1) >= 200, 32'h0));
      else              checkOutput("sweep_b_end", {33'd0, b_rd_valid}, 34'd0);
    end

    $display("[TB] writes and byte enables");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 8'(k), 32'h0BAD0000 + 32'(k), 4'hF, 1'b0, 8'd0);
      tick();
    end
    applyStimulus(1'b1, 8'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 8'd0);
    tick();
    applyStimulus(1'b1, 8'd5, 32'h11223344, 4'b0101, 1'b0, 8'd0);
    tick();
    applyStimulus(1'b1, 8'd5, 32'hFFFFFFFF, 4'b0000, 1'b0, 8'd0);
    tick();

    $display("[TB] back-to-back burst read 0..9");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, i < 10, 8'(i));
      tick();
      if (i < 10) checkOutput("burst_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, expBurst(i)));
      else        checkOutput("hold_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b0, 1'b0, expBurst(9)));
      if (i == 0)       checkOutput("burst_b_lat", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b0, 1'b0, 32'h0));
      else if (i <= 10) checkOutput("burst_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b0, expBurst(i - 1)));
      else              checkOutput("hold_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b0, 1'b0, expBurst(9)));
    end

    $display("[TB] out-of-range access");
    applyStimulus(1'b1, 8'd210, 32'h12345678, 4'hF, 1'b0, 8'd0);
    tick();
    checkOutput("oor_wr_err_b", {33'd0, b_wr_err}, 34'd1);
    checkOutput("oor_wr_err_a", {33'd0, a_wr_err}, 34'd0);
    idle();
    tick();
    checkOutput("oor_wr_err_pulse", {33'd0, b_wr_err}, 34'd0);
    applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd210);
    tick();
    checkOutput("oor_rd_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'h12345678));
    checkOutput("oor_rd_b_wait", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b0, 1'b0, expBurst(9)));
    idle();
    tick();
    checkOutput("oor_rd_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b1, 32'h0));
    tick();
    checkOutput("oor_rd_b_after", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b0, 1'b0, 32'h0));

    $display("[TB] read-during-write");
    applyStimulus(1'b1, 8'd7, 32'hAAAAAAAA, 4'hF, 1'b0, 8'd0);
    tick();
    applyStimulus(1'b1, 8'd7, 32'h55555555, 4'hF, 1'b1, 8'd7);
    tick();
    checkOutput("rdw_full_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'h55555555));
    applyStimulus(1'b1, 8'd7, 32'h12341234, 4'b0011, 1'b1, 8'd7);
    tick();
    checkOutput("rdw_part_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'h55551234));
    checkOutput("rdw_full_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b0, 32'hAAAAAAAA));
    applyStimulus(1'b1, 8'd8, 32'hCAFEF00D, 4'hF, 1'b1, 8'd7);
    tick();
    checkOutput("diff_addr_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'h55551234));
    checkOutput("rdw_part_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b0, 32'h55555555));
    applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd8);
    tick();
    checkOutput("diff_wr_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'hCAFEF00D));
    checkOutput("diff_addr_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b0, 32'h55551234));
    idle();
    tick();
    checkOutput("diff_wr_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b0, 32'hCAFEF00D));
    tick();

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
    tick();
    checkOutput("flight_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'hDE22BE44));
    rst = 1'b1;
    tick();
    checkOutput("flight_rst_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b0, 1'b0, 32'h0));
    checkOutput("flight_rst_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b0, 1'b0, 32'h0));
    idle();
    tick();
    checkOutput("flight_drop_b", {33'd0, b_rd_valid}, 34'd0);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (a_rd_valid || b_rd_valid || !a_init_busy || !b_init_busy) spurious++;
    end
    checkOutput("partial_init", 34'(spurious), 34'd0);
    rst = 1'b1;
    tick();
    checkOutput("reinit_busy", {32'd0, a_init_busy, b_init_busy}, 34'd3);
    rst = 1'b0;
    waitInit(1'b0, a_done, b_done, spurious);
    checkOutput("reinit_cycles_a", 34'(a_done), 34'd256);
    checkOutput("reinit_cycles_b", 34'(b_done), 34'd200);
    checkOutput("reinit_quiet", 34'(spurious), 34'd0);
    applyStimulus(1'b0, 8'd0, 32'd0, 4'd0, 1'b1, 8'd5);
    tick();
    checkOutput("cleared_a", pack(a_rd_valid, a_rd_err, a_rd_data), pack(1'b1, 1'b0, 32'h0));
    idle();
    tick();
    checkOutput("cleared_b", pack(b_rd_valid, b_rd_err, b_rd_data), pack(1'b1, 1'b0, 32'h0));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
